// File: rtl/serial_stream_tx.sv
// -----------------------------------------------------------------------------
// serial_stream_tx
// -----------------------------------------------------------------------------
// Parallel-to-serial transmitter feeding the single-bit stream used by the FSM
// pattern detectors. A WIDTH-bit word is accepted through a valid/ready
// handshake and then sent one bit per clock. After each frame the line is held
// at 0 for GAP_CYCLES idle cycles, and then the block becomes ready again.
//
// Parameters
//   WIDTH       frame length in bits (>= 2)
//   MSB_FIRST   1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   GAP_CYCLES  idle cycles after each frame before o_ready returns (>= 0)
//
// Ports
//   i_clk        clock, every flop samples on the rising edge
//   i_rst        synchronous, active-high reset
//   i_data       word to transmit, sampled only on accept
//   i_valid      i_data is valid
//   o_ready      block can accept a word (IDLE)
//   o_bit        serial data bit, forced to 0 whenever o_bit_valid is 0
//   o_bit_valid  o_bit carries a frame bit this cycle
//   o_bit_idx    ordinal of the current bit in the frame (0 = first sent)
//   o_busy       block is not IDLE
//   o_done       one-cycle pulse on the last bit of a frame
//
// Every output is decoded from registered state only, so no input reaches an
// output combinationally. The serial line therefore changes only on clock edges.
// -----------------------------------------------------------------------------
module serial_stream_tx #(
  parameter int WIDTH      = 32,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_bit,
  output logic                     o_bit_valid,
  output logic [$clog2(WIDTH)-1:0] o_bit_idx,
  output logic                     o_busy,
  output logic                     o_done
);

  // ---------------------------------------------------------------------------
  // Local constants
  // ---------------------------------------------------------------------------
  localparam int CW = $clog2(WIDTH);
  // The gap counter only needs to reach GAP_CYCLES-1. It keeps at least one
  // bit so that the design still elaborates cleanly when GAP_CYCLES is 0.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [WIDTH-1:0] SHREG_ZERO = {WIDTH{1'b0}};

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // This is resolved at elaboration time. It selects where a finished frame
  // goes next.
  localparam logic [1:0] ST_AFTER_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] shreg_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;
  logic [GW-1:0]    gap_r;
  logic [GW-1:0]    gap_s;

  logic             in_idle_s;
  logic             in_shift_s;
  logic             accept_s;
  logic             last_bit_s;
  logic             head_bit_s;
  logic [WIDTH-1:0] shreg_adv_s;

  assign in_idle_s  = (state_r == ST_IDLE);
  assign in_shift_s = (state_r == ST_SHIFT);
  // A word is taken only while IDLE. A request in any other state is dropped.
  assign accept_s   = i_valid & in_idle_s;
  assign last_bit_s = in_shift_s & (cnt_r == CNT_LAST);

  // The bit that is currently on the line sits at the output end of the
  // shift register.
  assign head_bit_s = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];

  // Shift register advanced by one position toward its output end.
  assign shreg_adv_s = MSB_FIRST ? {shreg_r[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg_r[WIDTH-1:1]};

  // Next-state logic for the IDLE / SHIFT / GAP sequencer and its datapath.
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    cnt_s   = cnt_r;
    gap_s   = gap_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          shreg_s = i_data;
          cnt_s   = CNT_ZERO;
          gap_s   = GAP_ZERO;
          state_s = ST_SHIFT;
        end else begin
          shreg_s = shreg_r;
          cnt_s   = CNT_ZERO;
          gap_s   = GAP_ZERO;
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          // Clear the datapath when the frame ends so that no frame data
          // lingers into the gap or the next IDLE period.
          shreg_s = SHREG_ZERO;
          cnt_s   = CNT_ZERO;
          gap_s   = GAP_ZERO;
          state_s = ST_AFTER_FRAME;
        end else begin
          shreg_s = shreg_adv_s;
          cnt_s   = cnt_r + CNT_ONE;
          gap_s   = GAP_ZERO;
          state_s = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          gap_s   = GAP_ZERO;
          state_s = ST_IDLE;
        end else begin
          gap_s   = gap_r + GAP_ONE;
          state_s = ST_GAP;
        end
      end
      default: begin
        // An unreachable encoding returns to a clean IDLE.
        shreg_s = SHREG_ZERO;
        cnt_s   = CNT_ZERO;
        gap_s   = GAP_ZERO;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State registers. The synchronous reset overrides everything, including a
  // simultaneous accept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      shreg_r <= SHREG_ZERO;
      cnt_r   <= CNT_ZERO;
      gap_r   <= GAP_ZERO;
    end else begin
      state_r <= state_s;
      shreg_r <= shreg_s;
      cnt_r   <= cnt_s;
      gap_r   <= gap_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered state only)
  // ---------------------------------------------------------------------------
  assign o_ready     = in_idle_s;
  assign o_busy      = ~in_idle_s;
  assign o_bit_valid = in_shift_s;
  // Gate the data bit so that no stray 1 reaches the detector outside a frame.
  assign o_bit       = in_shift_s & head_bit_s;
  assign o_bit_idx   = in_shift_s ? cnt_r : CNT_ZERO;
  assign o_done      = last_bit_s;

endmodule

// File: tb/tb_serial_stream_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_stream_tx
// Three transmitter instances share one clock and one reset:
//   A: WIDTH=32, MSB first, GAP_CYCLES=2
//   B: WIDTH=32, LSB first, GAP_CYCLES=2
//   C: WIDTH=8,  MSB first, GAP_CYCLES=0
// The expected line behaviour is built from the frame timeline:
//   - accept at edge k,
//   - bit n of the frame during cycle k+1+n,
//   - the gap,
//   - ready again.
// Each expected bit is extracted from the word with shifts.
// -----------------------------------------------------------------------------
module tb_serial_stream_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        valid_a, valid_b, valid_c;
  logic [31:0] data_a, data_b;
  logic [7:0]  data_c;
  logic        rdy_a, bit_a, bv_a, busy_a, done_a;
  logic        rdy_b, bit_b, bv_b, busy_b, done_b;
  logic        rdy_c, bit_c, bv_c, busy_c, done_c;
  logic [4:0]  idx_a, idx_b;
  logic [2:0]  idx_c;

  serial_stream_tx #(.WIDTH(32), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_valid(valid_a),
    .o_ready(rdy_a), .o_bit(bit_a), .o_bit_valid(bv_a), .o_bit_idx(idx_a),
    .o_busy(busy_a), .o_done(done_a));

  serial_stream_tx #(.WIDTH(32), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_valid(valid_b),
    .o_ready(rdy_b), .o_bit(bit_b), .o_bit_valid(bv_b), .o_bit_idx(idx_b),
    .o_busy(busy_b), .o_done(done_b));

  serial_stream_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_data(data_c), .i_valid(valid_c),
    .o_ready(rdy_c), .o_bit(bit_c), .o_bit_valid(bv_c), .o_bit_idx(idx_c),
    .o_busy(busy_c), .o_done(done_c));

  int   n_checks = 0;
  int   n_fail   = 0;
  int   t_accept = 0;
  logic frame_bits [32];

  // Observed status: {ready, bit_valid, bit, busy, done, idx[4:0]}
  function automatic logic [9:0] obs(input int sel);
    case (sel)
      0:       obs = {rdy_a, bv_a, bit_a, busy_a, done_a, idx_a};
      1:       obs = {rdy_b, bv_b, bit_b, busy_b, done_b, idx_b};
      default: obs = {rdy_c, bv_c, bit_c, busy_c, done_c, 2'b00, idx_c};
    endcase
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [31:0] d);
    case (sel)
      0:       begin valid_a = v; data_a = d;      end
      1:       begin valid_b = v; data_b = d;      end
      default: begin valid_c = v; data_c = d[7:0]; end
    endcase
  endtask

  // Sends word w on instance sel and checks every cycle from the accept until
  // ready returns.
  //   mode 0: valid drops after the accept.
  //   mode 1: random valid/data noise throughout the frame and the gap.
  //   mode 2: valid stays high with word nxt queued behind the frame.
  task automatic check_frame(input int sel, input logic [31:0] w, input int mode,
                             input logic [31:0] nxt, input string tag);
    int         width;
    bit         msb;
    int         gap;
    logic       eb;
    logic [9:0] got;
    logic [9:0] exp_v;
    width = (sel == 2) ? 8 : 32;
    msb   = (sel != 1);
    gap   = (sel == 2) ? 0 : 2;
    set_in(sel, 1'b1, w);
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    got = obs(sel);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s_idle_before got=%b exp=%b", tag, got, exp_v);
    end
    @(posedge clk); #1;
    t_accept = cyc;
    case (mode)
      0:       set_in(sel, 1'b0, $urandom);
      1:       set_in(sel, 1'($urandom_range(0, 1)), $urandom);
      default: set_in(sel, 1'b1, nxt);
    endcase
    for (int n = 0; n < width; n++) begin
      eb = msb ? 1'((w >> (width - 1 - n)) & 32'd1) : 1'((w >> n) & 32'd1);
      exp_v = {1'b0, 1'b1, eb, 1'b1, (n == width - 1), 5'(n)};
      got = obs(sel);
      frame_bits[n] = got[7];
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s_bit[%0d] got=%b exp=%b", tag, n, got, exp_v);
      end
      if (mode == 1) set_in(sel, 1'($urandom_range(0, 1)), $urandom);
      @(posedge clk); #1;
    end
    for (int g = 0; g < gap; g++) begin
      exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
      got = obs(sel);
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL %s_gap[%0d] got=%b exp=%b", tag, g, got, exp_v);
      end
      if (mode == 1) set_in(sel, 1'($urandom_range(0, 1)), $urandom);
      @(posedge clk); #1;
    end
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    got = obs(sel);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s_ready_after got=%b exp=%b", tag, got, exp_v);
    end
    if (mode != 2) set_in(sel, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst = 1'b1;
    // Valid is asserted during reset. Reset must win over the accept.
    for (int s = 0; s < 3; s++) set_in(s, 1'b1, $urandom);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      got = obs(s);
      n_checks++;
      if (got !== 10'b1000000000) begin
        n_fail++;
        $display("FAIL reset_state[%0d] got=%b exp=%b", s, got, 10'b1000000000);
      end
      set_in(s, 1'b0, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      got = obs(s);
      n_checks++;
      if (got !== 10'b1000000000) begin
        n_fail++;
        $display("FAIL reset_release[%0d] got=%b exp=%b", s, got, 10'b1000000000);
      end
    end
  endtask

  task automatic test_msb_first();
    int hits;
    check_frame(0, 32'hC000_0000, 0, 32'd0, "msb_c0");
    hits = 0;
    for (int n = 2; n < 32; n++)
      if (frame_bits[n-2] === 1'b1 && frame_bits[n-1] === 1'b1 && frame_bits[n] === 1'b0)
        hits++;
    n_checks++;
    if (hits !== 1) begin
      n_fail++;
      $display("FAIL det110_count got=%0d exp=%0d", hits, 1);
    end
    for (int r = 0; r < 3; r++) check_frame(0, $urandom, 0, 32'd0, "msb_rand");
  endtask

  task automatic test_lsb_first();
    check_frame(1, 32'h0000_0006, 0, 32'd0, "lsb_06");
    for (int r = 0; r < 3; r++) check_frame(1, $urandom, 0, 32'd0, "lsb_rand");
  endtask

  task automatic test_back_to_back();
    int t_first;
    check_frame(0, 32'hFFFF_FFFF, 2, 32'h0000_0000, "b2b_a");
    t_first = t_accept;
    check_frame(0, 32'h0000_0000, 0, 32'd0, "b2b_b");
    n_checks++;
    if ((t_accept - t_first) !== 35) begin
      n_fail++;
      $display("FAIL b2b_period got=%0d exp=%0d", t_accept - t_first, 35);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w;
    logic [9:0]  got;
    logic [9:0]  exp_v;
    w = 32'hAAAA_AAAA;
    set_in(0, 1'b1, w);
    @(posedge clk); #1;
    set_in(0, 1'b0, 32'd0);
    for (int n = 0; n <= 10; n++) begin
      exp_v = {1'b0, 1'b1, 1'((w >> (31 - n)) & 32'd1), 1'b1, 1'b0, 5'(n)};
      got = obs(0);
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL rstmid_bit[%0d] got=%b exp=%b", n, got, exp_v);
      end
      if (n == 10) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    got = obs(0);
    n_checks++;
    if (got !== 10'b1000000000) begin
      n_fail++;
      $display("FAIL rstmid_abort got=%b exp=%b", got, 10'b1000000000);
    end
    check_frame(0, $urandom, 0, 32'd0, "rstmid_next");
  endtask

  task automatic test_gap0();
    check_frame(2, 32'h0000_00B6, 0, 32'd0, "gap0_b6");
    for (int r = 0; r < 4; r++) check_frame(2, $urandom, 0, 32'd0, "gap0_rand");
  endtask

  task automatic test_ignore_valid();
    for (int r = 0; r < 2; r++) begin
      check_frame(0, $urandom, 1, 32'd0, "ign_a");
      check_frame(1, $urandom, 1, 32'd0, "ign_b");
      check_frame(2, $urandom, 1, 32'd0, "ign_c");
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    data_a = 32'd0; data_b = 32'd0; data_c = 8'd0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid_frame();
    test_gap0();
    test_ignore_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
